alu_issue_stage: RTL and testbench

Operand-fetch and write-back stage directly upstream of the 8-bit combinational ALU. Holds an 8×8-bit register file, accepts one instruction per cycle over a valid/ready handshake, and drives registered operands and the 3-bit select to the ALU. One cycle later it writes the ALU result back into the destination register. A forwarding path removes read-after-write hazards between back-to-back instructions, and a carry flag captures `cout` on ADD.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_issue_if.sv | 34 +++
 rtl/regfile_8x8.sv | 33 +++
 rtl/alu_issue_stage.sv | 77 +++++++
 tb/tb_alu_issue_stage.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: widths, opcode encoding, instruction layout.
// Pure declarations; no logic, no latency, no backpressure.
package alu_pkg;

  localparam int DATA_W = 8;
  localparam int NREGS  = 8;
  localparam int REG_AW = $clog2(NREGS);

  typedef enum logic [2:0] {
    OP_NEGA = 3'b000,
    OP_NEGB = 3'b001,
    OP_ADD  = 3'b010,
    OP_SUB  = 3'b011,
    OP_AND  = 3'b100,
    OP_OR   = 3'b101,
    OP_MUL  = 3'b110,
    OP_XOR  = 3'b111
  } alu_op_e;

  typedef struct packed {
    alu_op_e           op;
    logic [REG_AW-1:0] dst;
    logic [REG_AW-1:0] src1;
    logic [REG_AW-1:0] src2;
    logic              imm_sel;
    logic [DATA_W-1:0] imm;
  } instr_t;

endpackage

// File: rtl/alu_issue_if.sv
// Instruction handshake plus the ALU operand/result bus between issue stage and its neighbours.
// Wires only; no latency; the stage side drives in_ready as its backpressure.
interface alu_issue_if;
  import alu_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_op;
  logic [REG_AW-1:0] in_dst;
  logic [REG_AW-1:0] in_src1;
  logic [REG_AW-1:0] in_src2;
  logic              in_imm_sel;
  logic [DATA_W-1:0] in_imm;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [2:0]        alu_c;
  logic [DATA_W-1:0] alu_result;
  logic              alu_cout;
  logic              carry_flag;
  logic              wb_valid;

  modport slave (
    input  in_valid, in_op, in_dst, in_src1, in_src2, in_imm_sel, in_imm,
    input  alu_result, alu_cout,
    output in_ready, alu_a, alu_b, alu_c, carry_flag, wb_valid
  );

  modport master (
    output in_valid, in_op, in_dst, in_src1, in_src2, in_imm_sel, in_imm,
    output alu_result, alu_cout,
    input  in_ready, alu_a, alu_b, alu_c, carry_flag, wb_valid
  );

endinterface

// File: rtl/regfile_8x8.sv
// 8x8 register file, r0 hardwired to zero; two read ports plus a debug port, one write port.
// Reads combinational, write lands on the rising edge; no backpressure.
module regfile_8x8
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [REG_AW-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic [REG_AW-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0] regs [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we && waddr != '0) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1   = (raddr1   == '0) ? '0 : regs[raddr1];
  assign rdata2   = (raddr2   == '0) ? '0 : regs[raddr2];
  assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];

endmodule

// File: rtl/alu_issue_stage.sv
// Operand fetch + write-back around a combinational ALU; one EX register, result written one edge after accept.
// One instruction per cycle; stall freezes everything and drops in_ready.
module alu_issue_stage #(
  parameter int DATA_W = 8,
  parameter int NREGS  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     stall,
  input  logic [$clog2(NREGS)-1:0] dbg_addr,
  output logic [DATA_W-1:0]        dbg_data,
  alu_issue_if.slave               bus
);
  import alu_pkg::*;

  localparam int AW = $clog2(NREGS);

  instr_t          instr;
  logic            ex_vld;
  logic [AW-1:0]   ex_dst;
  logic [DATA_W-1:0] rd1, rd2, opa, opb;
  logic            accept, wb_en, fwd1, fwd2;

  assign instr = '{op:      alu_op_e'(bus.in_op),
                   dst:     bus.in_dst,
                   src1:    bus.in_src1,
                   src2:    bus.in_src2,
                   imm_sel: bus.in_imm_sel,
                   imm:     bus.in_imm};

  assign bus.in_ready = rst_n & ~stall;
  assign accept       = bus.in_valid & bus.in_ready;
  assign wb_en        = ex_vld & ~stall;
  assign bus.wb_valid = wb_en;

  // The in-flight result bypasses the array; r0 is never a forwarding source.
  assign fwd1 = ex_vld && (ex_dst != '0) && (ex_dst == instr.src1);
  assign fwd2 = ex_vld && (ex_dst != '0) && !instr.imm_sel && (ex_dst == instr.src2);
  assign opa  = fwd1 ? bus.alu_result : rd1;
  assign opb  = instr.imm_sel ? instr.imm : (fwd2 ? bus.alu_result : rd2);

  regfile_8x8 u_rf (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (wb_en),
    .waddr    (ex_dst),
    .wdata    (bus.alu_result),
    .raddr1   (instr.src1),
    .rdata1   (rd1),
    .raddr2   (instr.src2),
    .rdata2   (rd2),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_vld         <= 1'b0;
      ex_dst         <= '0;
      bus.alu_a      <= '0;
      bus.alu_b      <= '0;
      bus.alu_c      <= '0;
      bus.carry_flag <= 1'b0;
    end else if (!stall) begin
      if (wb_en && bus.alu_c == OP_ADD) bus.carry_flag <= bus.alu_cout;
      ex_vld <= accept;
      // Operands hold after the last issue so the ALU inputs stay quiet.
      if (accept) begin
        ex_dst    <= instr.dst;
        bus.alu_a <= opa;
        bus.alu_b <= opb;
        bus.alu_c <= instr.op;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a behavioural ALU closing the operand/result loop.
module tb_alu_issue_stage;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       stall;
  logic [2:0] dbg_addr;
  logic [7:0] dbg_data;
  int         n_pass = 0;
  int         n_total = 0;
  int         wb_cnt = 0;
  int         cnt0;

  alu_issue_if bus ();

  alu_issue_stage #(.DATA_W(8), .NREGS(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .stall    (stall),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  always_comb begin
    logic [8:0] sum;
    sum = '0;
    bus.alu_cout   = 1'b0;
    bus.alu_result = '0;
    case (bus.alu_c)
      3'b000: bus.alu_result = 8'h00 - bus.alu_a;
      3'b001: bus.alu_result = 8'h00 - bus.alu_b;
      3'b010: begin
        sum            = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
        bus.alu_result = sum[7:0];
        bus.alu_cout   = sum[8];
      end
      3'b011: bus.alu_result = bus.alu_a - bus.alu_b;
      3'b100: bus.alu_result = bus.alu_a & bus.alu_b;
      3'b101: bus.alu_result = bus.alu_a | bus.alu_b;
      3'b110: bus.alu_result = bus.alu_a * bus.alu_b;
      default: bus.alu_result = bus.alu_a ^ bus.alu_b;
    endcase
  end

  always @(posedge clk) if (bus.wb_valid) wb_cnt <= wb_cnt + 1;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
  endtask

  task automatic chk_dbg(input string tag, input logic [2:0] addr, input logic [7:0] exp);
    dbg_addr = addr;
    #1;
    check(tag, dbg_data, exp);
  endtask

  task automatic drive(input logic [2:0] op, input logic [2:0] dst, input logic [2:0] s1,
                       input logic [2:0] s2, input logic isel, input logic [7:0] imm);
    bus.in_op      = op;
    bus.in_dst     = dst;
    bus.in_src1    = s1;
    bus.in_src2    = s2;
    bus.in_imm_sel = isel;
    bus.in_imm     = imm;
    bus.in_valid   = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; dbg_addr = '0;
    bus.in_valid = 1'b0; bus.in_op = '0; bus.in_dst = '0; bus.in_src1 = '0;
    bus.in_src2 = '0; bus.in_imm_sel = 1'b0; bus.in_imm = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_in_ready", {7'b0, bus.in_ready}, 8'h00);
    check("rst_alu_a", bus.alu_a, 8'h00);
    check("rst_alu_b", bus.alu_b, 8'h00);
    check("rst_alu_c", {5'b0, bus.alu_c}, 8'h00);
    check("rst_carry", {7'b0, bus.carry_flag}, 8'h00);
    check("rst_wb_valid", {7'b0, bus.wb_valid}, 8'h00);
    rst_n = 1'b1;
    #1;
    check("ready_after_rst", {7'b0, bus.in_ready}, 8'h01);

    // reset then write: r1 = 0x05, r2 = 0x03
    drive(OP_OR, 3'd1, 3'd0, 3'd0, 1'b1, 8'h05);
    @(negedge clk);
    check("or1_alu_b", bus.alu_b, 8'h05);
    check("or1_alu_c", {5'b0, bus.alu_c}, 8'h05);
    check("or1_wb_valid", {7'b0, bus.wb_valid}, 8'h01);
    chk_dbg("dbg_r1_old", 3'd1, 8'h00);
    drive(OP_OR, 3'd2, 3'd0, 3'd0, 1'b1, 8'h03);
    @(negedge clk);
    chk_dbg("dbg_r1", 3'd1, 8'h05);
    // ADD r3 = r1 + r2; r2 is being written on this edge -> forwarded
    drive(OP_ADD, 3'd3, 3'd1, 3'd2, 1'b0, 8'h00);
    @(negedge clk);
    chk_dbg("dbg_r2", 3'd2, 8'h03);
    check("add_alu_a", bus.alu_a, 8'h05);
    check("add_fwd_b", bus.alu_b, 8'h03);
    drive(OP_XOR, 3'd4, 3'd3, 3'd1, 1'b0, 8'h00);
    @(negedge clk);
    check("xor_fwd_a", bus.alu_a, 8'h08);
    check("xor_alu_b", bus.alu_b, 8'h05);
    check("carry_add_nc", {7'b0, bus.carry_flag}, 8'h00);
    chk_dbg("dbg_r3", 3'd3, 8'h08);

    // carry capture
    drive(OP_OR, 3'd1, 3'd0, 3'd0, 1'b1, 8'hFF);
    @(negedge clk);
    chk_dbg("dbg_r4", 3'd4, 8'h0D);
    drive(OP_ADD, 3'd5, 3'd1, 3'd0, 1'b1, 8'h01);
    @(negedge clk);
    check("addc_fwd_a", bus.alu_a, 8'hFF);
    check("addc_alu_b", bus.alu_b, 8'h01);
    drive(OP_AND, 3'd6, 3'd1, 3'd0, 1'b1, 8'h0F);
    @(negedge clk);
    chk_dbg("dbg_r5", 3'd5, 8'h00);
    check("carry_set", {7'b0, bus.carry_flag}, 8'h01);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("carry_hold_and", {7'b0, bus.carry_flag}, 8'h01);
    chk_dbg("dbg_r6", 3'd6, 8'h0F);
    check("idle_wb_valid", {7'b0, bus.wb_valid}, 8'h00);
    check("idle_alu_c_hold", {5'b0, bus.alu_c}, 8'h04);

    // stall: ADD r7 = r1 + r2 = 0x02 held in EX for 3 cycles
    drive(OP_ADD, 3'd7, 3'd1, 3'd2, 1'b0, 8'h00);
    @(negedge clk);
    check("st_alu_a", bus.alu_a, 8'hFF);
    stall = 1'b1;
    drive(OP_OR, 3'd1, 3'd0, 3'd0, 1'b1, 8'h55);
    for (int k = 0; k < 3; k++) begin
      #1;
      check("st_in_ready", {7'b0, bus.in_ready}, 8'h00);
      check("st_wb_valid", {7'b0, bus.wb_valid}, 8'h00);
      check("st_alu_a_hold", bus.alu_a, 8'hFF);
      chk_dbg("st_r7", 3'd7, 8'h00);
      chk_dbg("st_r1", 3'd1, 8'hFF);
      @(negedge clk);
    end
    stall = 1'b0;
    bus.in_valid = 1'b0;
    cnt0 = wb_cnt;
    #1;
    check("unstall_wb_valid", {7'b0, bus.wb_valid}, 8'h01);
    @(negedge clk);
    chk_dbg("unstall_r7", 3'd7, 8'h02);
    @(negedge clk);
    check("unstall_wb_once", 8'(wb_cnt - cnt0), 8'h01);
    chk_dbg("r1_not_taken", 3'd1, 8'hFF);

    // r0 writes dropped and never forwarded
    drive(OP_ADD, 3'd0, 3'd2, 3'd0, 1'b1, 8'h04);
    @(negedge clk);
    check("r0_wb_valid", {7'b0, bus.wb_valid}, 8'h01);
    drive(OP_OR, 3'd3, 3'd0, 3'd0, 1'b1, 8'h10);
    @(negedge clk);
    check("r0_no_fwd", bus.alu_a, 8'h00);
    chk_dbg("dbg_r0", 3'd0, 8'h00);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk_dbg("dbg_r3_b", 3'd3, 8'h10);

    // reset while SUB r6 is in flight
    drive(OP_SUB, 3'd6, 3'd1, 3'd2, 1'b0, 8'h00);
    @(negedge clk);
    check("sub_alu_c", {5'b0, bus.alu_c}, 8'h03);
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    check("mrst_in_ready", {7'b0, bus.in_ready}, 8'h00);
    check("mrst_wb_valid", {7'b0, bus.wb_valid}, 8'h00);
    check("mrst_alu_a", bus.alu_a, 8'h00);
    check("mrst_alu_b", bus.alu_b, 8'h00);
    check("mrst_alu_c", {5'b0, bus.alu_c}, 8'h00);
    check("mrst_carry", {7'b0, bus.carry_flag}, 8'h00);
    chk_dbg("mrst_r1", 3'd1, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_dbg("mrst_r6", 3'd6, 8'h00);
    check("mrst_wb_after", {7'b0, bus.wb_valid}, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
